// File: rtl/bht_predictor.sv
// Branch history table: saturating direction counters indexed by fetch PC,
// optionally XORed with a resolve-time global history (gshare), plus accuracy statistics.
module bht_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned HIST_W  = 4,
    parameter int unsigned GSHARE  = 0,
    localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pred_valid_i,
    input  logic [31:0]       pred_pc_i,
    output logic              pred_taken_o,
    output logic [IDX_W-1:0]  pred_idx_o,
    input  logic              upd_valid_i,
    input  logic [IDX_W-1:0]  upd_idx_i,
    input  logic              upd_taken_i,
    input  logic              upd_mispredict_i,
    input  logic              clr_stats_i,
    output logic [HIST_W-1:0] ghr_o,
    output logic [31:0]       stat_lookups_o,
    output logic [31:0]       stat_mispred_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [31:0]      STAT_MAX = '1;

    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("bht_predictor: ENTRIES must be a power of two >= 2");
    end
    if (CNT_W < 1 || CNT_W > 4) begin : g_bad_cnt
        $error("bht_predictor: CNT_W must be 1..4");
    end
    if (HIST_W < 1 || HIST_W > IDX_W) begin : g_bad_hist
        $error("bht_predictor: HIST_W must be 1..IDX_W");
    end

    logic [CNT_W-1:0]  cnt_q [ENTRIES];
    logic [HIST_W-1:0] ghr_q;
    logic [HIST_W-1:0] ghr_nxt;
    logic [IDX_W-1:0]  base_idx;
    logic [CNT_W-1:0]  upd_cnt;
    logic [CNT_W-1:0]  upd_cnt_nxt;
    logic [31:0]       lookups_q;
    logic [31:0]       mispred_q;
    logic              unused_pc;

    // Only the word-aligned index bits of the PC take part in the lookup.
    assign base_idx  = pred_pc_i[IDX_W+1:2];
    assign unused_pc = ^{pred_pc_i[31:IDX_W+2], pred_pc_i[1:0]};

    if (GSHARE != 0) begin : g_gshare
        assign pred_idx_o = base_idx ^ IDX_W'(ghr_q);
    end else begin : g_bimodal
        assign pred_idx_o = base_idx;
    end

    assign pred_taken_o = cnt_q[pred_idx_o][CNT_W-1];

    if (HIST_W == 1) begin : g_hist_one
        assign ghr_nxt = upd_taken_i;
    end else begin : g_hist_many
        assign ghr_nxt = {ghr_q[HIST_W-2:0], upd_taken_i};
    end

    // Saturating step of the counter being trained.
    always_comb begin
        upd_cnt     = cnt_q[upd_idx_i];
        upd_cnt_nxt = upd_cnt;
        if (upd_taken_i) begin
            if (upd_cnt != CNT_MAX) begin
                upd_cnt_nxt = upd_cnt + CNT_W'(1);
            end
        end else if (upd_cnt != '0) begin
            upd_cnt_nxt = upd_cnt - CNT_W'(1);
        end
    end

    // Counter table and history; every entry re-initialises in the reset cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt_q[IDX_W'(i)] <= CNT_INIT;
            end
            ghr_q <= '0;
        end else if (upd_valid_i) begin
            cnt_q[upd_idx_i] <= upd_cnt_nxt;
            ghr_q            <= ghr_nxt;
        end
    end

    // Statistics saturate instead of wrapping; clear beats a coincident increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_stats_i) begin
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            if (pred_valid_i && lookups_q != STAT_MAX) begin
                lookups_q <= lookups_q + 32'd1;
            end
            if (upd_valid_i && upd_mispredict_i && mispred_q != STAT_MAX) begin
                mispred_q <= mispred_q + 32'd1;
            end
        end
    end

    assign ghr_o          = ghr_q;
    assign stat_lookups_o = lookups_q;
    assign stat_mispred_o = mispred_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: directed vector table plus a randomised phase against a reference model,
// run on a bimodal and a gshare instance sharing the same stimulus.
module tb_bht_predictor;

    typedef struct {
        logic        rst;
        logic        pv;
        logic [31:0] pc;
        logic        uv;
        logic [3:0]  ui;
        logic        ut;
        logic        um;
        logic        clr;
        logic        chk;
        logic        chk_g;
        logic        tk_b;
        logic [3:0]  idx_b;
        logic        tk_g;
        logic [3:0]  idx_g;
        logic [3:0]  ghr;
        logic [31:0] lk;
        logic [31:0] mp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        upd_valid = 1'b0;
    logic [3:0]  upd_idx = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic        clr_stats = 1'b0;

    logic        tk_b, tk_g;
    logic [3:0]  idx_b, idx_g, ghr_b, ghr_g;
    logic [31:0] lk_b, lk_g, mp_b, mp_g;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    bht_predictor #(.ENTRIES(16), .CNT_W(2), .HIST_W(4), .GSHARE(0)) u_bim (
        .clk_i(clk), .rst_i(rst), .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
        .pred_taken_o(tk_b), .pred_idx_o(idx_b), .upd_valid_i(upd_valid), .upd_idx_i(upd_idx),
        .upd_taken_i(upd_taken), .upd_mispredict_i(upd_mispredict), .clr_stats_i(clr_stats),
        .ghr_o(ghr_b), .stat_lookups_o(lk_b), .stat_mispred_o(mp_b)
    );

    bht_predictor #(.ENTRIES(16), .CNT_W(2), .HIST_W(4), .GSHARE(1)) u_gsh (
        .clk_i(clk), .rst_i(rst), .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
        .pred_taken_o(tk_g), .pred_idx_o(idx_g), .upd_valid_i(upd_valid), .upd_idx_i(upd_idx),
        .upd_taken_i(upd_taken), .upd_mispredict_i(upd_mispredict), .clr_stats_i(clr_stats),
        .ghr_o(ghr_g), .stat_lookups_o(lk_g), .stat_mispred_o(mp_g)
    );

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic pv, input logic [31:0] pc,
                                input logic uv, input logic [3:0] ui, input logic ut,
                                input logic um, input logic clr, input logic tkb,
                                input logic [3:0] ib, input logic [3:0] g,
                                input logic [31:0] lk, input logic [31:0] mp);
        vec_t v;
        v.rst = r; v.pv = pv; v.pc = pc; v.uv = uv; v.ui = ui; v.ut = ut; v.um = um; v.clr = clr;
        v.chk = 1'b1; v.chk_g = 1'b0; v.tk_b = tkb; v.idx_b = ib; v.tk_g = 1'b0; v.idx_g = '0;
        v.ghr = g; v.lk = lk; v.mp = mp;
        return v;
    endfunction

    function automatic vec_t mk_g(input logic [31:0] pc, input logic uv, input logic [3:0] ui,
                                  input logic ut, input logic tkb, input logic [3:0] ib,
                                  input logic tkg, input logic [3:0] ig, input logic [3:0] g);
        vec_t v;
        v = mk(1'b0, 1'b0, pc, uv, ui, ut, 1'b0, 1'b0, tkb, ib, g, 32'd0, 32'd0);
        v.chk_g = 1'b1; v.tk_g = tkg; v.idx_g = ig;
        return v;
    endfunction

    function automatic vec_t mk_rst();
        vec_t v;
        v = mk(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 32'd0);
        v.chk = 1'b0;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then compare before the next edge.
    task automatic step(input vec_t v, input int cyc);
        vec_t e;
        @(negedge clk);
        rst = v.rst; pred_valid = v.pv; pred_pc = v.pc; upd_valid = v.uv; upd_idx = v.ui;
        upd_taken = v.ut; upd_mispredict = v.um; clr_stats = v.clr;
        exp_q.push_back(v);
        #2;
        e = exp_q.pop_front();
        if (e.chk) begin
            check("bim_taken", cyc, 32'(tk_b), 32'(e.tk_b));
            check("bim_idx", cyc, 32'(idx_b), 32'(e.idx_b));
            check("bim_ghr", cyc, 32'(ghr_b), 32'(e.ghr));
            check("gsh_ghr", cyc, 32'(ghr_g), 32'(e.ghr));
            check("bim_lookups", cyc, lk_b, e.lk);
            check("bim_mispred", cyc, mp_b, e.mp);
            check("gsh_lookups", cyc, lk_g, e.lk);
            check("gsh_mispred", cyc, mp_g, e.mp);
        end
        if (e.chk_g) begin
            check("gsh_taken", cyc, 32'(tk_g), 32'(e.tk_g));
            check("gsh_idx", cyc, 32'(idx_g), 32'(e.idx_g));
        end
    endtask

    // Reference model for the randomised phase.
    int          m_cnt [16];
    logic [3:0]  m_ghr;
    logic [31:0] m_lk, m_mp;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_cnt[i] = 1;
        m_ghr = '0; m_lk = '0; m_mp = '0;
    endtask

    initial begin
        vec_t v;
        int   cyc;
        logic [3:0] bi, gi;

        vecs.push_back(mk_rst());
        vecs.push_back(mk_rst());
        // Reset defaults across the whole table.
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 0, 32'(i * 4), 0, 0, 0, 0, 0, 0, 4'(i), 4'h0, 0, 0));
        // Bimodal saturation on idx 0.
        vecs.push_back(mk(0, 0, 32'h40, 1, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h40, 1, 0, 1, 0, 0, 1, 0, 4'h1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h40, 1, 0, 1, 0, 0, 1, 0, 4'h3, 0, 0));
        vecs.push_back(mk(0, 0, 32'h40, 1, 0, 0, 0, 0, 1, 0, 4'h7, 0, 0));
        vecs.push_back(mk(0, 0, 32'h40, 1, 0, 0, 0, 0, 1, 0, 4'hE, 0, 0));
        vecs.push_back(mk(0, 0, 32'h40, 1, 0, 0, 0, 0, 0, 0, 4'hC, 0, 0));
        vecs.push_back(mk(0, 0, 32'h40, 1, 0, 0, 0, 0, 0, 0, 4'h8, 0, 0));
        vecs.push_back(mk(0, 0, 32'h40, 1, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 4'h1, 0, 0));
        // Aliasing: 0x80 shares idx 0, 0x44 is untouched.
        vecs.push_back(mk(0, 0, 32'h40, 1, 0, 1, 0, 0, 0, 0, 4'h1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h40, 1, 0, 1, 0, 0, 1, 0, 4'h3, 0, 0));
        vecs.push_back(mk(0, 0, 32'h80, 0, 0, 0, 0, 0, 1, 0, 4'h7, 0, 0));
        vecs.push_back(mk(0, 0, 32'h44, 0, 0, 0, 0, 0, 0, 1, 4'h7, 0, 0));
        // Same-cycle lookup/update collision, then back-to-back updates on idx 3.
        vecs.push_back(mk(0, 0, 32'h0C, 1, 3, 1, 0, 0, 0, 3, 4'h7, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0C, 0, 0, 0, 0, 0, 1, 3, 4'hF, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0C, 1, 3, 0, 0, 0, 1, 3, 4'hF, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0C, 1, 3, 0, 0, 0, 0, 3, 4'hE, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0C, 1, 3, 1, 0, 0, 0, 3, 4'hC, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0C, 1, 3, 1, 0, 0, 0, 3, 4'h9, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0C, 0, 0, 0, 0, 0, 1, 3, 4'h3, 0, 0));
        // Statistics: 5 lookups, 2 mispredicts, then clear beating an increment.
        vecs.push_back(mk(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, 4, 4'h3, 0, 0));
        vecs.push_back(mk(0, 1, 32'h14, 1, 7, 0, 1, 0, 0, 5, 4'h3, 1, 0));
        vecs.push_back(mk(0, 1, 32'h18, 0, 0, 0, 0, 0, 0, 6, 4'h6, 2, 1));
        vecs.push_back(mk(0, 1, 32'h1C, 1, 7, 1, 1, 0, 0, 7, 4'h6, 3, 1));
        vecs.push_back(mk(0, 1, 32'h20, 1, 8, 1, 0, 0, 0, 8, 4'hD, 4, 2));
        vecs.push_back(mk(0, 0, 32'h20, 0, 0, 0, 0, 0, 1, 8, 4'hB, 5, 2));
        vecs.push_back(mk(0, 1, 32'h24, 1, 9, 0, 1, 1, 0, 9, 4'hB, 5, 2));
        vecs.push_back(mk(0, 0, 32'h24, 0, 0, 0, 0, 0, 0, 9, 4'h6, 0, 0));
        // Mid-run reset overriding a coincident update and lookup count.
        vecs.push_back(mk(1, 1, 32'h00, 1, 0, 1, 0, 0, 1, 0, 4'h6, 0, 0));
        vecs.push_back(mk(0, 1, 32'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0C, 0, 0, 0, 0, 0, 0, 3, 4'h0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h20, 0, 0, 0, 0, 0, 0, 8, 4'h0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h00, 1, 0, 1, 0, 0, 0, 0, 4'h0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0, 0, 0, 1, 0, 4'h1, 1, 0));
        // Gshare: T,T,N,T on idx 5 gives history 1101.
        vecs.push_back(mk_rst());
        vecs.push_back(mk_g(32'h00, 1, 5, 1, 0, 4'h0, 0, 4'h0, 4'h0));
        vecs.push_back(mk_g(32'h00, 1, 5, 1, 0, 4'h0, 0, 4'h1, 4'h1));
        vecs.push_back(mk_g(32'h00, 1, 5, 0, 0, 4'h0, 0, 4'h3, 4'h3));
        vecs.push_back(mk_g(32'h00, 1, 5, 1, 0, 4'h0, 0, 4'h6, 4'h6));
        vecs.push_back(mk_g(32'h00, 0, 0, 0, 0, 4'h0, 0, 4'hD, 4'hD));
        vecs.push_back(mk_g(32'h34, 0, 0, 0, 0, 4'hD, 0, 4'h0, 4'hD));
        vecs.push_back(mk_g(32'h20, 0, 0, 0, 0, 4'h8, 1, 4'h5, 4'hD));
        vecs.push_back(mk_g(32'h14, 0, 0, 0, 1, 4'h5, 0, 4'h8, 4'hD));

        cyc = 0;
        foreach (vecs[k]) begin
            step(vecs[k], cyc);
            cyc++;
        end

        // Randomised phase checked against the reference model.
        step(mk_rst(), cyc);
        cyc++;
        model_reset();
        for (int n = 0; n < 400; n++) begin
            v.rst = ($urandom_range(0, 49) == 0);
            v.pv  = 1'($urandom_range(0, 1));
            v.pc  = $urandom;
            v.uv  = 1'($urandom_range(0, 1));
            v.ui  = 4'($urandom_range(0, 15));
            v.ut  = 1'($urandom_range(0, 1));
            v.um  = 1'($urandom_range(0, 1));
            v.clr = ($urandom_range(0, 15) == 0);
            bi = v.pc[5:2];
            gi = bi ^ m_ghr;
            v.chk = 1'b1; v.chk_g = 1'b1;
            v.idx_b = bi; v.idx_g = gi;
            v.tk_b = (m_cnt[bi] >= 2); v.tk_g = (m_cnt[gi] >= 2);
            v.ghr = m_ghr; v.lk = m_lk; v.mp = m_mp;
            step(v, cyc);
            cyc++;
            if (v.rst) begin
                model_reset();
            end else begin
                if (v.uv) begin
                    if (v.ut && m_cnt[v.ui] < 3) m_cnt[v.ui]++;
                    else if (!v.ut && m_cnt[v.ui] > 0) m_cnt[v.ui]--;
                    m_ghr = {m_ghr[2:0], v.ut};
                end
                if (v.clr) begin
                    m_lk = '0; m_mp = '0;
                end else begin
                    if (v.pv) m_lk++;
                    if (v.uv && v.um) m_mp++;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
